id_decode_stage: RTL
====================

// Module: id_decode_stage
// PURPOSE
//  ID stage of the 5-stage pipeline. Accepts one instruction per cycle from IF over valid/ready.
//  Splits the word into fields and drives imm16 to the external sign_extender.
//  Registers the decoded fields and extended immediate into the ID/EX register.
//  Inserts one bubble on a load-use hazard and honours EX back-pressure and flush.
// PARAMETERS
//  DATA_W     32     instruction / PC / immediate output width
//  LW_OPCODE  6'h23  opcode treated as a load for hazard detection
//  STALL_CW   16     width of saturating bubble counter
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       synchronous, active-high reset
//  if_valid      in   1       IF presents an instruction
//  if_instr      in   DATA_W  instruction word
//  if_pc         in   DATA_W  PC of if_instr
//  id_ready      out  1       ID accepts if_instr this cycle (combinational)
//  sext_in       out  16      = if_instr[15:0], to sign_extender.in_data
//  sext_out      in   32      from sign_extender.out_data (combinational return)
//  flush         in   1       kill ID/EX contents (branch/jump resolved)
//  ex_ready      in   1       EX can take the ID/EX register this cycle
//  ex_valid      out  1       ID/EX register holds a real instruction
//  ex_pc         out  DATA_W
//  ex_opcode     out  6
//  ex_funct      out  6
//  ex_shamt      out  5
//  ex_rs         out  5
//  ex_rt         out  5
//  ex_dest       out  5       rd if opcode==0, else rt
//  ex_imm        out  DATA_W  extended immediate
//  ex_reg_write  out  1       writes ex_dest (forced 0 when ex_dest==0)
//  ex_is_load    out  1       opcode==LW_OPCODE
//  stall_count   out  STALL_CW  load-use bubbles inserted, saturating
// BEHAVIOUR
//  - Reset: all ex_* outputs and stall_count are 0; ex_valid=0.
//  - id_ready = !hazard && (!ex_valid || ex_ready).
//  - hazard = if_valid && ex_valid && ex_is_load && ex_rt!=0 && (ex_rt==if_instr[25:21] || ex_rt==if_instr[20:16]).
//  - Accept (if_valid && id_ready): next edge loads all fields; ex_valid=1. Latency is 1 cycle.
//  - EX stalled (ex_valid && !ex_ready): ID/EX holds every bit; id_ready=0.
//  - Bubble: (!ex_valid || ex_ready) without accept gives ex_valid=0 at the next edge.
//    The payload may hold its old value.
//  - Hazard with ex_ready=1: insert exactly one bubble and increment stall_count.
//    The hazard clears automatically next cycle because ex_valid=0.
//  - Hazard with ex_ready=0: hold; no count increment.
//  - stall_count saturates at all-ones with no wrap.
//  - flush: ex_valid=0 at the next edge, regardless of if_valid, ex_ready or hazard.
//    It does not clear stall_count. Priority is rst > flush > hold > accept.
//  - Reset mid-stall: everything returns to reset values. There is no residual hazard.
//  - reg_write opcodes: 0x00 (R-type), 0x23, 0x08, 0x09, 0x0A, 0x0C, 0x0D, 0x0E, 0x0F.
//    All other opcodes give 0.
//  - ex_imm = sext_out, except as modified under CONFIGURATION.
// CONFIGURATION
//  ZERO_EXT_LOGICAL_EN
//    Defined: for opcodes 0x0C/0x0D/0x0E (ANDI/ORI/XORI), ex_imm = {16'b0, imm16}.
//    All other opcodes use sext_out.
//    Undefined: ex_imm = sext_out for every opcode.
// TESTING
//  1. rst=1 for 2 cycles -> all outputs 0; id_ready=1 with ex_ready=1.
//  2. Accept ADDI 0x2008FFFC with ex_ready=1 -> next cycle:
//     ex_valid=1, ex_dest=8, ex_imm=0xFFFFFFFC, ex_reg_write=1.
//  3. LW $9,0($8) then ADD $10,$9,$9 back-to-back -> one cycle with id_ready=0.
//     Next ex_valid=0 is the bubble; ADD enters the cycle after; stall_count=1.
//  4. Hold ex_ready=0 for 3 cycles with ex_valid=1 -> ID/EX is bit-stable.
//     id_ready=0; no instruction is lost or duplicated.
//  5. Assert flush alongside if_valid -> ex_valid=0 next cycle; instruction dropped.
//  6. ORI imm 0x8001 -> ex_imm=0x00008001 with ZERO_EXT_LOGICAL_EN defined.
//     Without it, ex_imm=0xFFFF8001.

Source files
------------

// File: rtl/id_decode_stage_if.sv
// ---------------------------------------------------------------------------
// id_decode_stage_if
//   Bundles the ID-stage bus. It carries three groups of signals:
//     - the IF->ID instruction handshake: if_valid, if_instr, if_pc, id_ready
//     - the sign-extender round trip: sext_in, sext_out
//     - the ID/EX register outputs and EX control: flush, ex_ready, ex_*,
//       stall_count
//   modport slave  : the decode stage itself
//   modport master : the surrounding pipeline (IF, sign extender, EX)
// ---------------------------------------------------------------------------
interface id_decode_stage_if #(
  parameter int DATA_W   = 32,
  parameter int STALL_CW = 16
);
  logic                if_valid;
  logic [DATA_W-1:0]   if_instr;
  logic [DATA_W-1:0]   if_pc;
  logic                id_ready;
  logic [15:0]         sext_in;
  logic [31:0]         sext_out;
  logic                flush;
  logic                ex_ready;
  logic                ex_valid;
  logic [DATA_W-1:0]   ex_pc;
  logic [5:0]          ex_opcode;
  logic [5:0]          ex_funct;
  logic [4:0]          ex_shamt;
  logic [4:0]          ex_rs;
  logic [4:0]          ex_rt;
  logic [4:0]          ex_dest;
  logic [DATA_W-1:0]   ex_imm;
  logic                ex_reg_write;
  logic                ex_is_load;
  logic [STALL_CW-1:0] stall_count;

  modport slave (
    input  if_valid, if_instr, if_pc, sext_out, flush, ex_ready,
    output id_ready, sext_in, ex_valid, ex_pc, ex_opcode, ex_funct, ex_shamt,
           ex_rs, ex_rt, ex_dest, ex_imm, ex_reg_write, ex_is_load, stall_count
  );

  modport master (
    output if_valid, if_instr, if_pc, sext_out, flush, ex_ready,
    input  id_ready, sext_in, ex_valid, ex_pc, ex_opcode, ex_funct, ex_shamt,
           ex_rs, ex_rt, ex_dest, ex_imm, ex_reg_write, ex_is_load, stall_count
  );
endinterface

// File: rtl/id_decode_stage.sv
// ---------------------------------------------------------------------------
// id_decode_stage
//   ID stage of a 5-stage pipeline. It takes one instruction per cycle from IF
//   over a valid/ready handshake and splits the word into its fields. It sends
//   imm16 out to an external sign extender and registers the decoded fields
//   into the ID/EX register. On a load-use hazard it inserts exactly one
//   bubble. It also honours EX back-pressure and flush.
//
//   Ports:
//     clk  : single clock, rising edge
//     rst  : synchronous, active-high reset
//     bus  : id_decode_stage_if.slave
//            - IF handshake    : if_valid, if_instr, if_pc, id_ready
//            - sign extender   : sext_in (imm16 out), sext_out (32b back)
//            - EX side         : flush, ex_ready, ex_* register outputs
//            - statistics      : stall_count (saturating bubble count)
//
//   Optional feature macro: ZERO_EXT_LOGICAL_EN
//     When it is defined, ANDI/ORI/XORI (opcodes 0x0C/0x0D/0x0E) zero-extend
//     imm16. Every other opcode uses sext_out.
// ---------------------------------------------------------------------------
module id_decode_stage #(
  parameter int         DATA_W    = 32,
  parameter logic [5:0] LW_OPCODE = 6'h23,
  parameter int         STALL_CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  id_decode_stage_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        dest;
    logic [DATA_W-1:0] imm;
    logic              reg_write;
    logic              is_load;
  } idex_t;

  idex_t               dec;
  idex_t               idex_d, idex_q;
  logic                ex_valid_d, ex_valid_q;
  logic [STALL_CW-1:0] stall_count_d, stall_count_q;

  logic hazard, advance, id_ready, accept;
  logic rw_opcode;

  assign bus.sext_in = bus.if_instr[15:0];

  // Field split and per-opcode control for the instruction currently offered.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    dec        = '0;
    rw_opcode  = 1'b0;
    dec.pc     = bus.if_pc;
    dec.opcode = bus.if_instr[31:26];
    dec.rs     = bus.if_instr[25:21];
    dec.rt     = bus.if_instr[20:16];
    dec.shamt  = bus.if_instr[10:6];
    dec.funct  = bus.if_instr[5:0];
    dec.dest   = (dec.opcode == 6'h00) ? bus.if_instr[15:11] : bus.if_instr[20:16];
    dec.is_load = (dec.opcode == LW_OPCODE);

    case (dec.opcode)
      6'h00, 6'h23, 6'h08, 6'h09, 6'h0A,
      6'h0C, 6'h0D, 6'h0E, 6'h0F: rw_opcode = 1'b1;
      default:                    rw_opcode = 1'b0;
    endcase
    // Register $0 is hard-wired, so a write to it is never requested.
    dec.reg_write = rw_opcode && (dec.dest != 5'd0);

`ifdef ZERO_EXT_LOGICAL_EN
    if (dec.opcode == 6'h0C || dec.opcode == 6'h0D || dec.opcode == 6'h0E)
      dec.imm = DATA_W'({16'b0, bus.if_instr[15:0]});
    else
      dec.imm = DATA_W'($signed(bus.sext_out));
`else
    dec.imm = DATA_W'($signed(bus.sext_out));
`endif
  end

  // The load in ID/EX writes a register that the offered instruction reads.
  assign hazard = bus.if_valid && ex_valid_q && idex_q.is_load && (idex_q.rt != 5'd0) &&
                  ((idex_q.rt == bus.if_instr[25:21]) || (idex_q.rt == bus.if_instr[20:16]));
  // The ID/EX register may change this cycle: it is empty, or EX is draining it.
  assign advance  = !ex_valid_q || bus.ex_ready;
  assign id_ready = !hazard && advance;
  assign accept   = bus.if_valid && id_ready;

  always_comb begin
    idex_d        = idex_q;
    ex_valid_d    = ex_valid_q;
    stall_count_d = stall_count_q;

    if (bus.flush) begin
      // The payload may keep stale bits; only the valid flag matters.
      ex_valid_d = 1'b0;
    end else if (!advance) begin
      ex_valid_d = ex_valid_q;
    end else if (accept) begin
      idex_d     = dec;
      ex_valid_d = 1'b1;
    end else begin
      // Bubble: this covers an idle IF as well as the load-use stall cycle.
      ex_valid_d = 1'b0;
    end

    // hazard implies ex_valid_q, so ex_ready alone means the bubble really goes in.
    if (hazard && bus.ex_ready && !bus.flush && (stall_count_q != '1))
      stall_count_d = stall_count_q + STALL_CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the payload is reset as well as the valid flag, because every ex_* output must read 0 after reset.
      idex_q        <= '0;
      ex_valid_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments give every flop its pre-edge value, whatever the statement order.
      idex_q        <= idex_d;
      ex_valid_q    <= ex_valid_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.id_ready     = id_ready;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_pc        = idex_q.pc;
  assign bus.ex_opcode    = idex_q.opcode;
  assign bus.ex_funct     = idex_q.funct;
  assign bus.ex_shamt     = idex_q.shamt;
  assign bus.ex_rs        = idex_q.rs;
  assign bus.ex_rt        = idex_q.rt;
  assign bus.ex_dest      = idex_q.dest;
  assign bus.ex_imm       = idex_q.imm;
  assign bus.ex_reg_write = idex_q.reg_write;
  assign bus.ex_is_load   = idex_q.is_load;
  assign bus.stall_count  = stall_count_q;

endmodule
